// File: rtl/cnn_layer_accel_ce_macc_chain_pkg.sv
// Shared package for the CE multiply-accumulate chain: word types built from
// the package widths, and the latency function the aligning logic is sized by.
package cnn_layer_accel_ce_pkg;

  localparam int A_W   = 27;
  localparam int B_W   = 18;
  localparam int ACC_W = 48;
  localparam int OUT_W = 32;

  typedef logic signed [A_W-1:0]   act_t;
  typedef logic signed [B_W-1:0]   weight_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Enabled cycles from an in_last beat to its out_valid.
  // Breakdown: A1, A2, M and P registers, plus NUM_TAPS-1 cascade hops,
  // plus the accumulator stage, which also loads the output register.
  function automatic int macc_chain_latency(input int num_taps);
    return num_taps + 32'sd4;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_ce_macc_chain_if.sv
// Beat/result bus of the CE MACC chain.
// The master drives beats and the slave (the chain) returns results.
interface cnn_layer_accel_ce_macc_chain_if #(
  parameter int NUM_TAPS  = 4,
  parameter int A_WIDTH   = 27,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32
);

  logic                          in_valid;
  logic                          in_first;
  logic                          in_last;
  logic [NUM_TAPS*A_WIDTH-1:0]   a;
  logic [NUM_TAPS*B_WIDTH-1:0]   b;
  logic [ACC_WIDTH-1:0]          bias;
  logic                          out_valid;
  logic [OUT_WIDTH-1:0]          out_data;
  logic                          out_sat;

  modport master (
    output in_valid, in_first, in_last, a, b, bias,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, a, b, bias,
    output out_valid, out_data, out_sat
  );

endinterface

// File: rtl/cnn_layer_accel_ce_macc_chain_tap.sv
// One DSP-style tap of the CE MACC cascade.
// The tap has two-stage A/B input registers and a product register M.
// Its cascade register P adds the upstream partial sum (pcin) to M.
module cnn_layer_accel_ce_macc_tap
  import cnn_layer_accel_ce_pkg::*;
#(
  parameter int A_WIDTH   = A_W,
  parameter int B_WIDTH   = B_W,
  parameter int ACC_WIDTH = ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic signed [ACC_WIDTH-1:0] pcin,
  output logic signed [ACC_WIDTH-1:0] pcout
);

  logic signed [A_WIDTH-1:0]         a1_r, a2_r;
  logic signed [B_WIDTH-1:0]         b1_r, b2_r;
  logic signed [A_WIDTH+B_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]       m_r, p_r;

  assign prod_s = a2_r * b2_r;
  assign pcout  = p_r;

  // Input pipeline, sign-extended product register and cascade adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_r <= '0;
      a2_r <= '0;
      b1_r <= '0;
      b2_r <= '0;
      m_r  <= '0;
      p_r  <= '0;
    end else if (ce) begin
      a1_r <= a;
      a2_r <= a1_r;
      b1_r <= b;
      b2_r <= b1_r;
      m_r  <= ACC_WIDTH'(prod_s);
      p_r  <= pcin + m_r;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_ce_macc_chain.sv
// CE multiply-accumulate chain.
// NUM_TAPS taps form a systolic cascade. A side pipeline carries the framing
// bits and the bias alongside it. A group accumulator feeds a scaled,
// registered result.
// Optional feature: define CE_MACC_SAT_EN to clip results to OUT_WIDTH and
// flag clipping on out_sat. When it is undefined, results are truncated.
module cnn_layer_accel_ce_macc_chain
  import cnn_layer_accel_ce_pkg::*;
#(
  parameter int NUM_TAPS  = 4,
  parameter int A_WIDTH   = A_W,
  parameter int B_WIDTH   = B_W,
  parameter int ACC_WIDTH = ACC_W,
  parameter int OUT_WIDTH = OUT_W,
  parameter int SHIFT     = 0
) (
  input  logic CLK,
  input  logic rst,
  input  logic ce,
  cnn_layer_accel_ce_macc_chain_if.slave bus
);

  // The side pipeline lands on the cycle in which the last cascade register
  // holds the beat's dot product. The accumulator stage then takes one more.
  localparam int SIDE_DEPTH = macc_chain_latency(NUM_TAPS) - 1;

  logic signed [ACC_WIDTH-1:0] p_chain_s [NUM_TAPS+1];

  logic [SIDE_DEPTH-1:0]       valid_pipe_r;
  logic [SIDE_DEPTH-1:0]       first_pipe_r;
  logic [SIDE_DEPTH-1:0]       last_pipe_r;
  logic signed [ACC_WIDTH-1:0] bias_pipe_r [SIDE_DEPTH];

  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic                        emit_s;
  logic [OUT_WIDTH:0]          scaled_s;

  logic                        out_valid_r;
  logic [OUT_WIDTH-1:0]        out_data_r;
  logic                        out_sat_r;

  // Reduce an accumulator word to the output: arithmetic shift, then either
  // clip (bit OUT_WIDTH is the clip flag) or keep the low OUT_WIDTH bits.
  function automatic logic [OUT_WIDTH:0] scale_word(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH-1:0] sh;
    logic [OUT_WIDTH:0]          res;
    sh  = x >>> SHIFT;
`ifdef CE_MACC_SAT_EN
    // In range iff every bit from the output sign bit upward is identical.
    if ((&sh[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|sh[ACC_WIDTH-1:OUT_WIDTH-1])) begin
      res = {1'b0, OUT_WIDTH'(sh)};
    end else if (sh[ACC_WIDTH-1]) begin
      res = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    res = {1'b0, OUT_WIDTH'(sh)};
`endif
    return res;
  endfunction

  assign p_chain_s[0] = '0;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    logic signed [A_WIDTH-1:0] tap_a_s;
    logic signed [B_WIDTH-1:0] tap_b_s;

    if (i == 0) begin : g_direct
      assign tap_a_s = bus.a[A_WIDTH-1:0];
      assign tap_b_s = bus.b[B_WIDTH-1:0];
    end else begin : g_skew
      logic signed [A_WIDTH-1:0] a_skew_r [i];
      logic signed [B_WIDTH-1:0] b_skew_r [i];

      // Delay tap i by i cycles so its operands meet the partial sum from tap i-1.
      always_ff @(posedge CLK) begin
        if (rst) begin
          for (int k = 0; k < i; k++) begin
            a_skew_r[k] <= '0;
            b_skew_r[k] <= '0;
          end
        end else if (ce) begin
          a_skew_r[0] <= bus.a[i*A_WIDTH +: A_WIDTH];
          b_skew_r[0] <= bus.b[i*B_WIDTH +: B_WIDTH];
          for (int k = 1; k < i; k++) begin
            a_skew_r[k] <= a_skew_r[k-1];
            b_skew_r[k] <= b_skew_r[k-1];
          end
        end
      end

      assign tap_a_s = a_skew_r[i-1];
      assign tap_b_s = b_skew_r[i-1];
    end

    cnn_layer_accel_ce_macc_tap #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_tap (
      .clk   (CLK),
      .rst   (rst),
      .ce    (ce),
      .a     (tap_a_s),
      .b     (tap_b_s),
      .pcin  (p_chain_s[i]),
      .pcout (p_chain_s[i+1])
    );
  end

  // Framing side pipeline; first/last are qualified by valid on entry so bubbles carry nothing.
  always_ff @(posedge CLK) begin
    if (rst) begin
      valid_pipe_r <= '0;
      first_pipe_r <= '0;
      last_pipe_r  <= '0;
    end else if (ce) begin
      valid_pipe_r <= {valid_pipe_r[SIDE_DEPTH-2:0], bus.in_valid};
      first_pipe_r <= {first_pipe_r[SIDE_DEPTH-2:0], bus.in_valid & bus.in_first};
      last_pipe_r  <= {last_pipe_r[SIDE_DEPTH-2:0],  bus.in_valid & bus.in_last};
    end
  end

  // Bias side pipeline; only the copy that arrives with a first beat is ever used.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int k = 0; k < SIDE_DEPTH; k++) begin
        bias_pipe_r[k] <= '0;
      end
    end else if (ce) begin
      bias_pipe_r[0] <= bus.bias;
      for (int k = 1; k < SIDE_DEPTH; k++) begin
        bias_pipe_r[k] <= bias_pipe_r[k-1];
      end
    end
  end

  // Group accumulation: a first beat reloads from bias (restarting any open group), others add on.
  always_comb begin
    acc_next_s = acc_r;
    emit_s     = 1'b0;
    if (valid_pipe_r[SIDE_DEPTH-1]) begin
      if (first_pipe_r[SIDE_DEPTH-1]) begin
        acc_next_s = bias_pipe_r[SIDE_DEPTH-1] + p_chain_s[NUM_TAPS];
      end else begin
        acc_next_s = acc_r + p_chain_s[NUM_TAPS];
      end
      emit_s = last_pipe_r[SIDE_DEPTH-1];
    end else begin
      acc_next_s = acc_r;
      emit_s     = 1'b0;
    end
  end

  assign scaled_s = scale_word(acc_next_s);

  // Accumulator register and result register; out_data/out_sat keep the last result between groups.
  always_ff @(posedge CLK) begin
    if (rst) begin
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if (ce) begin
      acc_r       <= acc_next_s;
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_data_r <= scaled_s[OUT_WIDTH-1:0];
        out_sat_r  <= scaled_s[OUT_WIDTH];
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_cnn_layer_accel_ce_macc_chain.sv
// Self-checking bench for the CE MACC chain.
// Two instances share the same stimulus: one has a 32-bit result and one a
// 16-bit result, the latter to reach the reduction boundary. A group-level
// reference model predicts each result and the enabled cycle it is due.
// Expectations follow CE_MACC_SAT_EN when it is defined.
module tb_cnn_layer_accel_ce_macc_chain;

  localparam int NT    = 4;
  localparam int AW    = 27;
  localparam int BW    = 18;
  localparam int ACCW  = 48;
  localparam int SHIFT = 0;
  localparam int LAT   = NT + 4;

  logic CLK = 1'b0;
  logic rst;
  logic ce;
  logic in_valid, in_first, in_last;
  logic [NT*AW-1:0] a_v;
  logic [NT*BW-1:0] b_v;
  logic [ACCW-1:0]  bias_v;

  always #5 CLK = ~CLK;

  cnn_layer_accel_ce_macc_chain_if #(.NUM_TAPS(NT), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(32)) bus32 ();
  cnn_layer_accel_ce_macc_chain_if #(.NUM_TAPS(NT), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(16)) bus16 ();

  assign bus32.in_valid = in_valid;
  assign bus32.in_first = in_first;
  assign bus32.in_last  = in_last;
  assign bus32.a        = a_v;
  assign bus32.b        = b_v;
  assign bus32.bias     = bias_v;
  assign bus16.in_valid = in_valid;
  assign bus16.in_first = in_first;
  assign bus16.in_last  = in_last;
  assign bus16.a        = a_v;
  assign bus16.b        = b_v;
  assign bus16.bias     = bias_v;

  cnn_layer_accel_ce_macc_chain #(.NUM_TAPS(NT), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(32), .SHIFT(SHIFT)) dut32 (
    .CLK (CLK), .rst (rst), .ce (ce), .bus (bus32));

  cnn_layer_accel_ce_macc_chain #(.NUM_TAPS(NT), .A_WIDTH(AW), .B_WIDTH(BW),
    .ACC_WIDTH(ACCW), .OUT_WIDTH(16), .SHIFT(SHIFT)) dut16 (
    .CLK (CLK), .rst (rst), .ce (ce), .bus (bus16));

  typedef struct {
    int          due;
    logic [31:0] d32;
    logic        s32;
    logic [15:0] d16;
    logic        s16;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [47:0] m_acc;
  int                en_cnt;
  logic              m_ov;
  logic [31:0]       m_d32;
  logic              m_s32;
  logic [15:0]       m_d16;
  logic              m_s16;
  int                checks;
  int                errors;

  function automatic logic [NT*AW-1:0] pack_a(input int x0, input int x1, input int x2, input int x3);
    logic [NT*AW-1:0] r;
    r = {27'(x3), 27'(x2), 27'(x1), 27'(x0)};
    return r;
  endfunction

  function automatic logic [NT*BW-1:0] pack_b(input int x0, input int x1, input int x2, input int x3);
    logic [NT*BW-1:0] r;
    r = {18'(x3), 18'(x2), 18'(x1), 18'(x0)};
    return r;
  endfunction

  // Plain signed dot product, wrapped to the accumulator width.
  function automatic logic signed [47:0] dot(input logic [NT*AW-1:0] av, input logic [NT*BW-1:0] bv);
    logic signed [47:0] s;
    logic signed [26:0] x;
    logic signed [17:0] y;
    longint             p;
    s = 48'sd0;
    for (int i = 0; i < NT; i++) begin
      x = av[i*AW +: AW];
      y = bv[i*BW +: BW];
      p = longint'(x) * longint'(y);
      s = s + p[47:0];
    end
    return s;
  endfunction

  // Shift, then clip or truncate to w bits.
  function automatic void scale(input logic signed [47:0] acc, input int w,
                                output logic [31:0] d, output logic s);
    longint v;
    longint mx;
    longint mn;
    v  = longint'(acc >>> SHIFT);
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    d  = v[31:0];
    s  = 1'b0;
`ifdef CE_MACC_SAT_EN
    if (v > mx) begin
      d = mx[31:0];
      s = 1'b1;
    end else if (v < mn) begin
      d = mn[31:0];
      s = 1'b1;
    end
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // Drive one cycle, advance the model by the same cycle, then compare both instances.
  task automatic step(input logic v, input logic f, input logic l,
                      input logic [NT*AW-1:0] av, input logic [NT*BW-1:0] bv,
                      input logic [ACCW-1:0] bs, input logic c, input logic r);
    exp_t e;
    logic [31:0] d;
    logic s;
    in_valid = v; in_first = f; in_last = l;
    a_v = av; b_v = bv; bias_v = bs; ce = c; rst = r;
    @(posedge CLK);
    #1;
    if (r) begin
      m_acc = 48'sd0;
      exp_q.delete();
      m_ov = 1'b0; m_d32 = 32'd0; m_s32 = 1'b0; m_d16 = 16'd0; m_s16 = 1'b0;
    end else if (c) begin
      en_cnt++;
      if (v) begin
        m_acc = f ? (signed'(bs) + dot(av, bv)) : (m_acc + dot(av, bv));
        if (l) begin
          e.due = en_cnt + LAT - 1;
          scale(m_acc, 32, d, s);
          e.d32 = d; e.s32 = s;
          scale(m_acc, 16, d, s);
          e.d16 = d[15:0]; e.s16 = s;
          exp_q.push_back(e);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
        e = exp_q.pop_front();
        m_ov = 1'b1; m_d32 = e.d32; m_s32 = e.s32; m_d16 = e.d16; m_s16 = e.s16;
      end else begin
        m_ov = 1'b0;
      end
    end
    chk("out_valid32", {31'd0, bus32.out_valid}, {31'd0, m_ov});
    chk("out_valid16", {31'd0, bus16.out_valid}, {31'd0, m_ov});
    if (m_ov || r) begin
      chk("out_data32", bus32.out_data, m_d32);
      chk("out_sat32",  {31'd0, bus32.out_sat}, {31'd0, m_s32});
      chk("out_data16", {16'd0, bus16.out_data}, {16'd0, m_d16});
      chk("out_sat16",  {31'd0, bus16.out_sat}, {31'd0, m_s16});
    end
  endtask

  // Bubbles with first/last raised but valid low; they must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 1'b1, pack_a(7, 7, 7, 7), pack_b(9, 9, 9, 9), 48'd5, 1'b1, 1'b0);
    end
  endtask

  logic [127:0] ra;
  logic [127:0] rb;
  logic [63:0]  rbias;

  initial begin
    checks = 0; errors = 0; en_cnt = 0; m_acc = 48'sd0;
    m_ov = 1'b0; m_d32 = 32'd0; m_s32 = 1'b0; m_d16 = 16'd0; m_s16 = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a_v = '0; b_v = '0; bias_v = '0; ce = 1'b1; rst = 1'b1;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    idle(2);

    // Single-beat group: 5+12+21+32+10 = 80.
    step(1'b1, 1'b1, 1'b1, pack_a(1, 2, 3, 4), pack_b(5, 6, 7, 8), 48'd10, 1'b1, 1'b0);
    idle(LAT + 2);

    // Three-beat group (24), then a single-beat group with bias -8 (0).
    step(1'b1, 1'b1, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), -48'sd8, 1'b1, 1'b0);
    idle(LAT + 2);

    // Signed operands: 4 * (-3 * 100) = -1200.
    step(1'b1, 1'b1, 1'b1, pack_a(-3, -3, -3, -3), pack_b(100, 100, 100, 100), 48'd0, 1'b1, 1'b0);
    idle(LAT + 2);

    // Three-beat group with a 3-cycle ce stall after the second beat.
    step(1'b1, 1'b1, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, pack_a(9, 9, 9, 9), pack_b(9, 9, 9, 9), 48'd3, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    idle(LAT - 1);
    // The result is now showing; stall so it must stay frozen.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    end
    idle(3);

    // Reduction boundary: 16384 * 16384 = 2^28.
    step(1'b1, 1'b1, 1'b1, pack_a(16384, 0, 0, 0), pack_b(16384, 0, 0, 0), 48'd0, 1'b1, 1'b0);
    idle(LAT + 2);

    // Reset on the second beat aborts the group; a fresh group then gives 80.
    step(1'b1, 1'b1, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, pack_a(1, 1, 1, 1), pack_b(2, 2, 2, 2), 48'd0, 1'b1, 1'b1);
    idle(LAT + 2);
    step(1'b1, 1'b1, 1'b1, pack_a(1, 2, 3, 4), pack_b(5, 6, 7, 8), 48'd10, 1'b1, 1'b0);
    idle(LAT + 2);

    // Randomized traffic: framing, bubbles, stalls and occasional resets.
    for (int n = 0; n < 600; n++) begin
      ra    = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb    = {$urandom(), $urandom(), $urandom(), $urandom()};
      rbias = {$urandom(), $urandom()};
      step(($urandom() % 4) != 0, ($urandom() % 4) == 0, ($urandom() % 3) == 0,
           ra[NT*AW-1:0], rb[NT*BW-1:0], rbias[ACCW-1:0],
           ($urandom() % 8) != 0, ($urandom() % 150) == 0);
    end
    idle(LAT + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_ce_macc_chain.md
# cnn_layer_accel_ce_macc_chain

Parametrised multiply-accumulate chain for the convolution engine (CE). It computes a NUM_TAPS-wide dot product every cycle through a systolic cascade of inferred DSP slices, adds an optional bias, and accumulates across a framed group of beats. It emits one scaled result per group. It replaces single-slice MACC instances where a kernel row needs several taps summed in the cascade path.

## Interface
- NUM_TAPS, 4: number of multiplier taps in the cascade (≥1)
- A_WIDTH, 27: signed activation width per tap
- B_WIDTH, 18: signed weight width per tap
- ACC_WIDTH, 48: accumulator and cascade width (≥ A_WIDTH+B_WIDTH+clog2(NUM_TAPS))
- OUT_WIDTH, 32: result width
- SHIFT, 0: arithmetic right shift applied to the accumulator before output

Ports:
- CLK  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  global clock enable; 0 freezes all state
- in_valid  in  1  beat valid
- in_first  in  1  first beat of group; qualified by in_valid
- in_last  in  1  last beat of group; qualified by in_valid
- a  in  NUM_TAPS×A_WIDTH  signed activations, tap 0 in LSBs
- b  in  NUM_TAPS×B_WIDTH  signed weights, tap 0 in LSBs
- bias  in  ACC_WIDTH  signed bias, sampled only on an in_first beat
- out_valid  out  1  result valid, one cycle per group
- out_data  out  OUT_WIDTH  signed result
- out_sat  out  1  result was clipped (0 when the macro is absent)

## Operation
- The caller presents all taps on the same cycle. Tap i is delayed internally by i cycles (skew registers) to align with the cascade.
- Per tap: two input register stages (A1/A2, B1/B2), one product register (M), one cascade register (P). P_i = P_{i-1} + M_i; P_0 = M_0.
- Products are sign-extended to ACC_WIDTH. All sums wrap in two's complement at ACC_WIDTH.
- in_valid, in_first, in_last and bias travel in a side pipeline matched to the cascade depth.
- Accumulator stage on an aligned valid beat:
  - if first, acc = bias + P_last
  - otherwise acc = acc + P_last
- On an aligned last beat, the next cycle sets out_valid=1 and out_data=scale(acc_new).
- first and last on the same beat form a single-beat group.
- in_valid=0 cycles are bubbles. The accumulator holds, and first/last are ignored.
- A first arriving while a group is open (no last seen) restarts the group. The prior partial result is discarded and nothing is emitted.
- A beat without first, arriving when no group is open, accumulates onto the stale acc. Framing is the caller's responsibility. This behaviour is defined, not an error.
- scale(x) = x >>> SHIFT (arithmetic), then reduced to OUT_WIDTH per Configuration.

## Timing
- Latency: from the in_last beat to out_valid is NUM_TAPS+4 enabled cycles (8 at the default).
- Throughput: one beat per cycle, with no back-pressure.
- Groups may be back-to-back: a last on cycle t and a first on cycle t+1 give two results one cycle apart.
- ce=0: every register holds, including out_valid and out_data. The consumer qualifies out_valid with ce. Latency counts only ce=1 cycles.
- rst (takes priority over ce): out_valid=0, out_data=0, out_sat=0. All valid, first and last pipeline bits are cleared, and acc=0.
- A reset mid-group loses that group. The first group after reset must begin with in_first.

## Configuration
- CE_MACC_SAT_EN defined: the scaled value is clipped to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. out_sat=1 with the result when clipping occurred.
- CE_MACC_SAT_EN undefined: the scaled value is truncated to its low OUT_WIDTH bits, and out_sat is tied to 0.

## Structure
- Shared package cnn_layer_accel_ce_pkg holds:
  - the signed typedefs for activation, weight and accumulator words, derived from package constants
  - the latency constant function macc_chain_latency(NUM_TAPS) = NUM_TAPS+4, which aligning logic must use
- Sub-module cnn_layer_accel_ce_macc_tap is a single tap: A/B input registers, M register, and P cascade register with a pcin input. It is instantiated NUM_TAPS times by generate.
- The skew registers, side pipeline, accumulator and output scaling stay in the top module.

## Test plan
- Single-beat group, defaults: a={1,2,3,4}, b={5,6,7,8}, bias=10, first=last=1 → out_data=80 exactly 8 cycles later, out_valid high for one cycle.
- Three-beat group: a=1 on every tap, b=2 on every tap, bias=0 → out_data=24. An immediately following single-beat group with the same data and bias=−8 → out_data=0 one cycle later.
- Signed operands: all a=−3, all b=100, bias=0, single beat → out_data=−1200.
- ce=0 for 3 cycles mid-group, during the three-beat case above → out_data=24, arriving exactly 3 cycles later than the no-stall run. out_valid and out_data are frozen while ce=0.
- OUT_WIDTH=16, a0=16384, b0=16384, other taps 0 → with macro: out_data=32767, out_sat=1. Without macro: out_data=0, out_sat=0.
- rst asserted on the second beat of a three-beat group, then a fresh single-beat case from the first scenario → no out_valid for the aborted group, then out_data=80 after 8 cycles.
